i2c_ram_bank_controller: RTL and testbench

Parametrised multi-bank display/data RAM controller for the I2C master board. It serves the menu controller (ROM page reads, RAM reads and writes), the I2C master engine (write of received bytes, read of bytes to transmit) and a multi-cycle clear engine. Bank 0 is the read-only menu ROM; banks 1..NUM_BANKS-1 are RAMs. Bank 1 is the master-receive RAM and bank 2 the slave-transmit RAM. Arbitration is explicit and dropped writes are reported.

---
 rtl/i2c_ram_pkg.sv | 45 ++++
 rtl/i2c_ram_bank_controller_if.sv | 45 ++++
 rtl/i2c_ram_clear_engine.sv | 78 +++++++
 rtl/i2c_ram_bank_controller.sv | 128 ++++++++++++
 tb/tb_i2c_ram_bank_controller.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_ram_pkg.sv
// Shared constants, clear-engine state type and menu ROM text for the I2C RAM bank controller.
package i2c_ram_pkg;

   localparam int unsigned BANK_MENU   = 0;
   localparam int unsigned BANK_MASTER = 1;
   localparam int unsigned BANK_SLAVE  = 2;

   localparam int unsigned MENU_MAIN   = 0;
   localparam int unsigned MENU_READ   = 1;
   localparam int unsigned MENU_WRITE  = 2;
   localparam int unsigned MENU_ADDR   = 3;
   localparam int unsigned MENU_DATA   = 4;
   localparam int unsigned MENU_SCAN   = 5;
   localparam int unsigned MENU_STATUS = 6;
   localparam int unsigned MENU_CLEAR  = 7;
   localparam int unsigned MENU_YES    = 8;
   localparam int unsigned MENU_NO     = 9;

   localparam logic [7:0] CHAR_SPACE = 8'h20;
   localparam logic [7:0] CHAR_FILL  = 8'hFE;

   typedef enum logic [1:0] {IDLE, CLEAR, DONE} clr_state_e;

   // 16-character pages, text left-justified and padded with spaces.
   function automatic logic [7:0] menu_char(input logic [3:0] page, input logic [3:0] idx);
      logic [127:0] text;
      logic [127:0] shifted;
      case (page)
         4'(MENU_MAIN):   text = {"MAIN",   {12{CHAR_SPACE}}};
         4'(MENU_READ):   text = {"READ",   {12{CHAR_SPACE}}};
         4'(MENU_WRITE):  text = {"WRITE",  {11{CHAR_SPACE}}};
         4'(MENU_ADDR):   text = {"ADDR",   {12{CHAR_SPACE}}};
         4'(MENU_DATA):   text = {"DATA",   {12{CHAR_SPACE}}};
         4'(MENU_SCAN):   text = {"SCAN",   {12{CHAR_SPACE}}};
         4'(MENU_STATUS): text = {"STATUS", {10{CHAR_SPACE}}};
         4'(MENU_CLEAR):  text = {"CLEAR",  {11{CHAR_SPACE}}};
         4'(MENU_YES):    text = {"YES",    {13{CHAR_SPACE}}};
         4'(MENU_NO):     text = {"NO",     {14{CHAR_SPACE}}};
         default:         text = {16{CHAR_SPACE}};
      endcase
      shifted = text << {idx, 3'b000};
      return shifted[127:120];
   endfunction

endpackage

// File: rtl/i2c_ram_bank_controller_if.sv
// Bus bundle between the menu/I2C/clear clients and the RAM bank controller.
interface i2c_ram_bank_controller_if #(
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned ADDR_W     = 5,
   parameter int unsigned NUM_BANKS  = 3,
   parameter int unsigned MENU_PAGES = 11
);
   localparam int unsigned BSEL_W = $clog2(NUM_BANKS);
   localparam int unsigned MSEL_W = $clog2(MENU_PAGES);

   logic [MSEL_W-1:0] menu_sel;
   logic [BSEL_W-1:0] rd_sel;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data;
   logic              rd_valid;
   logic              rd_en;
   logic              ui_wr;
   logic [BSEL_W-1:0] ui_wsel;
   logic [ADDR_W-1:0] ui_waddr;
   logic [DATA_W-1:0] ui_wdata;
   logic              ui_wr_drop;
   logic              m_wr;
   logic [ADDR_W-1:0] m_waddr;
   logic [DATA_W-1:0] m_wdata;
   logic [ADDR_W-1:0] s_raddr;
   logic [DATA_W-1:0] s_rdata;
   logic              clr_req;
   logic [BSEL_W-1:0] clr_sel;
   logic              clr_busy;
   logic              clr_done;
   logic              clr_err;

   modport slave (
      input  menu_sel, rd_sel, rd_addr, rd_en, ui_wr, ui_wsel, ui_waddr, ui_wdata,
             m_wr, m_waddr, m_wdata, s_raddr, clr_req, clr_sel,
      output rd_data, rd_valid, ui_wr_drop, s_rdata, clr_busy, clr_done, clr_err
   );

   modport master (
      output menu_sel, rd_sel, rd_addr, rd_en, ui_wr, ui_wsel, ui_waddr, ui_wdata,
             m_wr, m_waddr, m_wdata, s_raddr, clr_req, clr_sel,
      input  rd_data, rd_valid, ui_wr_drop, s_rdata, clr_busy, clr_done, clr_err
   );

endinterface

// File: rtl/i2c_ram_clear_engine.sv
// Sequential bank clear: walks every address of the selected RAM bank once.
module i2c_ram_clear_engine
   import i2c_ram_pkg::*;
#(
   parameter int unsigned ADDR_W    = 5,
   parameter int unsigned NUM_BANKS = 3,
   parameter int unsigned BSEL_W    = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req,
   input  logic [BSEL_W-1:0] sel,
   output logic              clr_we,
   output logic [BSEL_W-1:0] clr_bank,
   output logic [ADDR_W-1:0] clr_addr,
   output logic              busy,
   output logic              done,
   output logic              err
);

   clr_state_e        st_q, st_d;
   logic [ADDR_W:0]   cnt_q, cnt_d;
   logic [BSEL_W-1:0] bank_q, bank_d;
   logic              err_q, err_d;
   logic              sel_ok;

   assign sel_ok = (sel != '0) && (32'(sel) < NUM_BANKS);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         st_q   <= IDLE;
         cnt_q  <= '0;
         bank_q <= '0;
         err_q  <= 1'b0;
      end else begin
         st_q   <= st_d;
         cnt_q  <= cnt_d;
         bank_q <= bank_d;
         err_q  <= err_d;
      end
   end

   always_comb begin
      st_d   = st_q;
      cnt_d  = cnt_q;
      bank_d = bank_q;
      err_d  = 1'b0;
      unique case (st_q)
         IDLE: begin
            if (req) begin
               if (sel_ok) begin
                  st_d   = CLEAR;
                  cnt_d  = '0;
                  bank_d = sel;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         CLEAR: begin
            // MSB of the extended counter marks that the last address was just written.
            cnt_d = cnt_q + (ADDR_W+1)'(1);
            if (cnt_d[ADDR_W]) st_d = DONE;
         end
         DONE:    st_d = IDLE;
         default: st_d = IDLE;
      endcase
   end

   // A reset landing mid-clear must not complete the pending word.
   assign clr_we   = (st_q == CLEAR) && rst_n;
   assign clr_bank = bank_q;
   assign clr_addr = cnt_q[ADDR_W-1:0];
   assign busy     = (st_q == CLEAR);
   assign done     = (st_q == DONE);
   assign err      = err_q;

endmodule

// File: rtl/i2c_ram_bank_controller.sv
// Menu ROM plus RAM banks with per-bank write arbitration (clear > I2C master > menu).
module i2c_ram_bank_controller
   import i2c_ram_pkg::*;
#(
   parameter int unsigned       DATA_W     = 8,
   parameter int unsigned       ADDR_W     = 5,
   parameter int unsigned       NUM_BANKS  = 3,
   parameter int unsigned       MENU_PAGES = 11,
   parameter logic [DATA_W-1:0] CLEAR_CHAR = CHAR_SPACE
) (
   input logic                      clk,
   input logic                      rst_n,
   i2c_ram_bank_controller_if.slave bus
);

   localparam int unsigned BSEL_W = $clog2(NUM_BANKS);
   localparam int unsigned DEPTH  = 2**ADDR_W;

   logic              clr_we;
   logic [BSEL_W-1:0] clr_bank;
   logic [ADDR_W-1:0] clr_addr;

   i2c_ram_clear_engine #(
      .ADDR_W   (ADDR_W),
      .NUM_BANKS(NUM_BANKS),
      .BSEL_W   (BSEL_W)
   ) u_clear (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (bus.clr_req),
      .sel     (bus.clr_sel),
      .clr_we  (clr_we),
      .clr_bank(clr_bank),
      .clr_addr(clr_addr),
      .busy    (bus.clr_busy),
      .done    (bus.clr_done),
      .err     (bus.clr_err)
   );

   logic [DATA_W-1:0] rom_byte;
   logic [DATA_W-1:0] bank_rd [NUM_BANKS];
   logic [DATA_W-1:0] slave_rd;
   logic [DATA_W-1:0] rd_sel_data;

   // Only the low nibble of rd_addr indexes a 16-character menu page.
   always_comb begin
      if (32'(bus.menu_sel) >= MENU_PAGES) begin
         rom_byte = DATA_W'(CHAR_FILL);
      end else begin
         rom_byte = DATA_W'(menu_char(4'(bus.menu_sel), bus.rd_addr[3:0]));
      end
   end

   assign bank_rd[BANK_MENU] = rom_byte;

   for (genvar b = 1; b < NUM_BANKS; b++) begin : g_bank
      localparam bit IsMaster = (b == int'(BANK_MASTER));

      logic [DATA_W-1:0] mem [DEPTH];
      logic              we;
      logic [ADDR_W-1:0] waddr;
      logic [DATA_W-1:0] wdata;

      always_comb begin
         we    = 1'b0;
         waddr = bus.ui_waddr;
         wdata = bus.ui_wdata;
         if (clr_we && (clr_bank == BSEL_W'(b))) begin
            we    = 1'b1;
            waddr = clr_addr;
            wdata = CLEAR_CHAR;
         end else if (IsMaster && bus.m_wr) begin
            we    = 1'b1;
            waddr = bus.m_waddr;
            wdata = bus.m_wdata;
         end else if (bus.ui_wr && (bus.ui_wsel == BSEL_W'(b))) begin
            we = 1'b1;
         end
      end

      always_ff @(posedge clk) begin
         if (we) mem[waddr] <= wdata;
      end

      assign bank_rd[b] = mem[bus.rd_addr];

      if (b == int'(BANK_SLAVE)) begin : g_slave
         assign slave_rd = mem[bus.s_raddr];
      end
   end

   always_comb begin
      rd_sel_data = '0;
      if (32'(bus.rd_sel) < NUM_BANKS) rd_sel_data = bank_rd[bus.rd_sel];
   end

   logic ui_bad;
   assign ui_bad = bus.ui_wr &&
                   ((bus.ui_wsel == BSEL_W'(BANK_MENU)) ||
                    (32'(bus.ui_wsel) >= NUM_BANKS) ||
                    ((bus.ui_wsel == BSEL_W'(BANK_MASTER)) && bus.m_wr) ||
                    (clr_we && (bus.ui_wsel == clr_bank)));

   logic [DATA_W-1:0] rd_data_q;
   logic              rd_valid_q;
   logic [DATA_W-1:0] s_rdata_q;
   logic              drop_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         s_rdata_q  <= '0;
         drop_q     <= 1'b0;
      end else begin
         rd_valid_q <= bus.rd_en;
         if (bus.rd_en) rd_data_q <= rd_sel_data;
         s_rdata_q  <= slave_rd;
         drop_q     <= ui_bad;
      end
   end

   assign bus.rd_data    = rd_data_q;
   assign bus.rd_valid   = rd_valid_q;
   assign bus.s_rdata    = s_rdata_q;
   assign bus.ui_wr_drop = drop_q;

endmodule

// File: tb/tb_i2c_ram_bank_controller.sv
// Directed bench with a word-level memory/clear model checked against the controller every cycle.
module tb_i2c_ram_bank_controller;

   logic clk;
   logic rst_n;

   i2c_ram_bank_controller_if #(
      .DATA_W(8), .ADDR_W(5), .NUM_BANKS(3), .MENU_PAGES(11)
   ) bus ();

   i2c_ram_bank_controller #(
      .DATA_W(8), .ADDR_W(5), .NUM_BANKS(3), .MENU_PAGES(11), .CLEAR_CHAR(8'h20)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   int tests = 0;
   int fails = 0;
   bit chk_en = 0;

   // Model state: memory words, which words are known, pending clear.
   logic [7:0] mm [3][32];
   bit         mk [3][32];
   int         m_left = 0;
   int         m_bank = 0;
   bit         m_done = 0;

   logic [7:0] exp_rd = 0, exp_s = 0;
   bit exp_rdk = 1, exp_sk = 1;
   bit exp_rv = 0, exp_drop = 0, exp_busy = 0, exp_done = 0, exp_err = 0;

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      tests++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
      end
   endtask

   function automatic logic [7:0] rom_model(input int idx);
      logic [7:0] txt [4];
      txt = '{8'h4D, 8'h41, 8'h49, 8'h4E};
      return (idx < 4) ? txt[idx] : 8'h20;
   endfunction

   task automatic tick();
      logic [7:0] n_rd, n_s;
      bit n_rdk, n_sk, n_rv, n_drop, n_busy, n_done, n_err;
      int new_left, new_bank, ca, ws;
      bit new_done, cw, m_ok, ui_ok;
      ws = int'(bus.ui_wsel);
      cw = rst_n && (m_left > 0);
      ca = 32 - m_left;
      new_left = m_left; new_bank = m_bank; new_done = 0;
      n_err = 0;
      if (!rst_n) begin
         n_rd = 0; n_rdk = 1; n_rv = 0; n_s = 0; n_sk = 1; n_drop = 0;
         new_left = 0;
      end else begin
         n_rv = bus.rd_en;
         n_rd = exp_rd; n_rdk = exp_rdk;
         if (bus.rd_en) begin
            if (bus.rd_sel == 0) begin
               n_rdk = 1;
               if (int'(bus.menu_sel) >= 11) n_rd = 8'hFE;
               else if (bus.menu_sel == 0) n_rd = rom_model(int'(bus.rd_addr[3:0]));
               else n_rdk = 0;
            end else if (bus.rd_sel >= 3) begin
               n_rd = 0; n_rdk = 1;
            end else begin
               n_rd = mm[bus.rd_sel][bus.rd_addr]; n_rdk = mk[bus.rd_sel][bus.rd_addr];
            end
         end
         n_s = mm[2][bus.s_raddr]; n_sk = mk[2][bus.s_raddr];
         n_drop = bus.ui_wr && (ws == 0 || ws >= 3 || (ws == 1 && bus.m_wr) ||
                                (cw && ws == m_bank));
         if (cw) begin
            new_left = m_left - 1;
            new_done = (new_left == 0);
         end else if (!m_done && bus.clr_req) begin
            if (bus.clr_sel inside {2'd1, 2'd2}) begin
               new_left = 32; new_bank = int'(bus.clr_sel);
            end else begin
               n_err = 1;
            end
         end
      end
      n_busy = new_left > 0;
      n_done = new_done;
      m_ok  = bus.m_wr && !(cw && m_bank == 1);
      ui_ok = bus.ui_wr && (ws == 1 || ws == 2) && !(ws == 1 && bus.m_wr) &&
              !(cw && ws == m_bank);
      @(posedge clk);
      if (cw) begin mm[m_bank][ca] = 8'h20; mk[m_bank][ca] = 1; end
      if (m_ok) begin mm[1][bus.m_waddr] = bus.m_wdata; mk[1][bus.m_waddr] = 1; end
      if (ui_ok) begin mm[ws][bus.ui_waddr] = bus.ui_wdata; mk[ws][bus.ui_waddr] = 1; end
      exp_rd = n_rd; exp_rdk = n_rdk; exp_rv = n_rv; exp_s = n_s; exp_sk = n_sk;
      exp_drop = n_drop; exp_busy = n_busy; exp_done = n_done; exp_err = n_err;
      m_left = new_left; m_bank = new_bank; m_done = new_done;
      #1;
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (chk_en) begin
            if (exp_rdk) check("m_rd_data", bus.rd_data, exp_rd);
            if (exp_sk) check("m_s_rdata", bus.s_rdata, exp_s);
            check("m_rd_valid", bus.rd_valid, exp_rv);
            check("m_ui_wr_drop", bus.ui_wr_drop, exp_drop);
            check("m_clr_busy", bus.clr_busy, exp_busy);
            check("m_clr_done", bus.clr_done, exp_done);
            check("m_clr_err", bus.clr_err, exp_err);
         end
      end
   end

   task automatic fill(input int b, input int base);
      for (int a = 0; a < 32; a++) begin
         bus.ui_wr = 1; bus.ui_wsel = 2'(b); bus.ui_waddr = 5'(a);
         bus.ui_wdata = (base < 0) ? 8'h55 : 8'(base + a);
         tick();
      end
      bus.ui_wr = 0;
   endtask

   task automatic run_clear(input int sel, input bit disturb);
      int busy_cnt = 0;
      int done_at = 0;
      bus.clr_req = 1; bus.clr_sel = 2'(sel);
      tick();
      bus.clr_req = 0;
      for (int c = 1; c <= 40; c++) begin
         if (bus.clr_busy) busy_cnt++;
         if (bus.clr_done && done_at == 0) done_at = c;
         if (disturb && c == 8) check("clr_ui_drop", bus.ui_wr_drop, 1);
         if (disturb && c == 5) begin bus.clr_req = 1; bus.clr_sel = 2'(3 - sel); end
         if (disturb && c == 7) begin
            bus.ui_wr = 1; bus.ui_wsel = 2'(sel); bus.ui_waddr = 5'd31; bus.ui_wdata = 8'h99;
         end
         if (disturb && c == 9) begin bus.m_wr = 1; bus.m_waddr = 5'd0; bus.m_wdata = 8'h77; end
         tick();
         bus.clr_req = 0; bus.ui_wr = 0; bus.m_wr = 0;
      end
      check("clr_busy_cycles", busy_cnt, 32);
      check("clr_done_cycle", done_at, 33);
   endtask

   initial begin
      logic [7:0] rom_exp [4];
      bit done_seen;
      rom_exp = '{8'h4D, 8'h41, 8'h49, 8'h4E};
      rst_n = 0;
      bus.menu_sel = 0; bus.rd_sel = 0; bus.rd_addr = 0; bus.rd_en = 0;
      bus.ui_wr = 0; bus.ui_wsel = 0; bus.ui_waddr = 0; bus.ui_wdata = 0;
      bus.m_wr = 0; bus.m_waddr = 0; bus.m_wdata = 0; bus.s_raddr = 0;
      bus.clr_req = 0; bus.clr_sel = 0;
      tick();
      chk_en = 1;
      tick(); tick();
      check("rst_rd_data", bus.rd_data, 0);
      check("rst_rd_valid", bus.rd_valid, 0);
      check("rst_s_rdata", bus.s_rdata, 0);
      check("rst_busy", bus.clr_busy, 0);
      check("rst_done", bus.clr_done, 0);
      check("rst_err", bus.clr_err, 0);
      check("rst_drop", bus.ui_wr_drop, 0);
      rst_n = 1;

      fill(1, 8'h10);
      fill(2, 8'h40);

      for (int i = 0; i < 4; i++) begin
         bus.rd_en = 1; bus.rd_sel = 0; bus.menu_sel = 0; bus.rd_addr = 5'(i);
         tick();
         check("rom_rd_data", bus.rd_data, rom_exp[i]);
         check("rom_rd_valid", bus.rd_valid, 1);
      end
      bus.menu_sel = 4'd15; bus.rd_addr = 5'd2;
      tick();
      check("rom_bad_page", bus.rd_data, 8'hFE);
      bus.rd_en = 0;
      tick();
      check("rd_hold_valid", bus.rd_valid, 0);
      check("rd_hold_data", bus.rd_data, 8'hFE);
      bus.rd_en = 1; bus.rd_sel = 2'd3;
      tick();
      check("rd_bad_bank", bus.rd_data, 0);
      bus.rd_en = 0; bus.menu_sel = 0;

      bus.ui_wr = 1; bus.ui_wsel = 2'd2; bus.ui_waddr = 5'd5; bus.ui_wdata = 8'hA5;
      tick();
      bus.ui_wr = 0;
      check("ui_ok_drop", bus.ui_wr_drop, 0);
      bus.s_raddr = 5'd5;
      tick();
      check("s_rdata_a5", bus.s_rdata, 8'hA5);
      bus.ui_wr = 1; bus.ui_wsel = 2'd0; bus.ui_waddr = 5'd1; bus.ui_wdata = 8'hA5;
      tick();
      bus.ui_wr = 0;
      check("rom_wr_drop", bus.ui_wr_drop, 1);
      tick();
      check("rom_wr_drop_end", bus.ui_wr_drop, 0);
      bus.rd_en = 1; bus.rd_sel = 0; bus.rd_addr = 5'd1;
      tick();
      bus.rd_en = 0;
      check("rom_unchanged", bus.rd_data, 8'h41);
      bus.ui_wr = 1; bus.ui_wsel = 2'd3;
      tick();
      bus.ui_wr = 0;
      check("bad_bank_drop", bus.ui_wr_drop, 1);

      bus.m_wr = 1; bus.m_waddr = 5'd3; bus.m_wdata = 8'h11;
      bus.ui_wr = 1; bus.ui_wsel = 2'd1; bus.ui_waddr = 5'd3; bus.ui_wdata = 8'h22;
      tick();
      bus.m_wr = 0; bus.ui_wr = 0;
      check("collide_drop", bus.ui_wr_drop, 1);
      tick();
      check("collide_drop_end", bus.ui_wr_drop, 0);
      bus.rd_en = 1; bus.rd_sel = 2'd1; bus.rd_addr = 5'd3;
      tick();
      bus.rd_en = 0;
      check("collide_m_wins", bus.rd_data, 8'h11);

      fill(2, -1);
      run_clear(2, 0);
      for (int a = 0; a < 32; a++) begin
         bus.s_raddr = 5'(a);
         tick();
         check("clr_word", bus.s_rdata, 8'h20);
      end
      bus.rd_en = 1; bus.rd_sel = 2'd1; bus.rd_addr = 5'd0;
      tick();
      check("bank1_untouched0", bus.rd_data, 8'h10);
      bus.rd_addr = 5'd3;
      tick();
      bus.rd_en = 0;
      check("bank1_untouched3", bus.rd_data, 8'h11);

      bus.clr_req = 1; bus.clr_sel = 2'd0;
      tick();
      bus.clr_req = 0;
      check("clr_err_rom", bus.clr_err, 1);
      check("clr_err_busy", bus.clr_busy, 0);
      tick();
      check("clr_err_pulse", bus.clr_err, 0);
      bus.clr_req = 1; bus.clr_sel = 2'd3;
      tick();
      bus.clr_req = 0;
      check("clr_err_range", bus.clr_err, 1);

      run_clear(1, 1);

      fill(2, -1);
      bus.clr_req = 1; bus.clr_sel = 2'd2;
      tick();
      bus.clr_req = 0;
      repeat (10) tick();
      rst_n = 0;
      tick();
      check("rst_mid_busy", bus.clr_busy, 0);
      rst_n = 1;
      done_seen = 0;
      for (int c = 0; c < 40; c++) begin
         tick();
         if (bus.clr_done) done_seen = 1;
      end
      check("rst_mid_no_done", done_seen, 0);
      for (int a = 0; a < 32; a++) begin
         bus.rd_en = 1; bus.rd_sel = 2'd2; bus.rd_addr = 5'(a);
         tick();
         check("rst_mid_word", bus.rd_data, (a < 10) ? 8'h20 : 8'h55);
      end
      bus.rd_en = 0;
      tick();

      chk_en = 0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
